// File: rtl/alu_wb_stage.sv
// alu_wb_stage
//   Writeback/status stage behind the 8-bit ALU. Each accepted ALU beat is
//   queued in a small circular skid buffer. The register-file write port
//   drains that buffer over a valid/ready handshake. On the same accept edge
//   the beat can update the architectural flag register (carry, shift-carry,
//   gt, eq). The flag outputs feed back to the ALU and to the branch unit.
//
// Ports
//   Clk, Reset               clock, asynchronous active-high reset
//   in_valid / in_ready      ALU beat handshake (in_ready = not full)
//   Rslt, wr_addr, wr_en_in  beat payload stored in the buffer
//   Co, SCo, gt, eq, clear   ALU status inputs for the flag register
//   flag_we, flag_clr        flag update enable / clear (clear wins)
//   out_valid / out_ready    register-file handshake for the head entry
//   wb_data, wb_addr, wb_en  head entry toward the register file
//   Ci_q, SCi_q, gt_q, eq_q  registered flags
//   count                    number of entries held
module alu_wb_stage #(
  parameter int DW    = 8,
  parameter int AW    = 3,
  parameter int DEPTH = 2
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            Rslt,
  input  logic                     Co,
  input  logic                     SCo,
  input  logic                     gt,
  input  logic                     eq,
  input  logic                     clear,
  input  logic                     wr_en_in,
  input  logic [AW-1:0]            wr_addr,
  input  logic                     flag_we,
  input  logic                     flag_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            wb_data,
  output logic [AW-1:0]            wb_addr,
  output logic                     wb_en,
  output logic                     Ci_q,
  output logic                     SCi_q,
  output logic                     gt_q,
  output logic                     eq_q,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = DW + AW + 1;

  // Entry layout: {data, addr, write-enable}
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] hold_data_q, hold_data_d;
  logic [AW-1:0] hold_addr_q, hold_addr_d;
  logic          ci_d, sci_d, gt_d, eq_d;

  logic          push, pop;
  logic [EW-1:0] head;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign head      = mem_q[rd_ptr_q];

  // While empty, wb_data/wb_addr show the last entry handed to the register file.
  // The slot under rd_ptr can hold an older entry at that point.
  assign wb_data = out_valid ? head[EW-1 -: DW] : hold_data_q;
  assign wb_addr = out_valid ? head[AW:1]       : hold_addr_q;
  assign wb_en   = out_valid & head[0];
  assign count   = count_q;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    hold_data_d = hold_data_q;
    hold_addr_d = hold_addr_q;
    ci_d        = Ci_q;
    sci_d       = SCi_q;
    gt_d        = gt_q;
    eq_d        = eq_q;

    if (push) begin
      mem_d[wr_ptr_q] = {Rslt, wr_addr, wr_en_in};
      // DEPTH is a power of two, so natural overflow of the pointer gives the wrap.
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      hold_data_d = head[EW-1 -: DW];
      hold_addr_d = head[AW:1];
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (flag_clr) begin
      ci_d  = 1'b0;
      sci_d = 1'b0;
      gt_d  = 1'b0;
      eq_d  = 1'b0;
    end else if (push && flag_we) begin
      ci_d  = Co;
      sci_d = clear ? 1'b0 : SCo;
      gt_d  = gt;
      eq_d  = eq;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hold_data_q <= '0;
      hold_addr_q <= '0;
      Ci_q        <= 1'b0;
      SCi_q       <= 1'b0;
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      hold_data_q <= hold_data_d;
      hold_addr_q <= hold_addr_d;
      Ci_q        <= ci_d;
      SCi_q       <= sci_d;
      gt_q        <= gt_d;
      eq_q        <= eq_d;
    end
  end

endmodule
